text_memory_loader: RTL

//  UART bootloader that writes TextMemory, which the core reads. Receives a framed
//  8N1 program image from a host and writes it word by word into TextMemory's write port.

---
 rtl/text_memory_loader_pkg.sv | 23 ++
 rtl/text_memory_loader_uart_rx.sv | 102 ++++++++++
 rtl/text_memory_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/text_memory_loader_pkg.sv
// Shared definitions for the UART TextMemory bootloader: state encodings and frame constants.
package text_memory_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_LEN,
      LD_DATA,
      LD_CSUM,
      LD_RUN
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned BYTES_PER_WORD    = 4;

endpackage

// File: rtl/text_memory_loader_uart_rx.sv
// 8N1 UART receiver: synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx_byte
   import text_memory_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]     DATA_LAST = 3'(UART_DATA_BITS - 1);

   rx_state_t     state_q, state_d;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (rx_prev && !rx_sync) state_d = RX_START;
         end
         RX_START: begin
            // A start bit no longer low at half-bit time is treated as a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift_q[7:1]};
               if (bit_q == DATA_LAST) state_d = RX_STOP;
               else                    bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = rx_sync;
               ferr_d  = !rx_sync;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign data       = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/text_memory_loader.sv
// UART bootloader: parses SYNC/LEN/data/CSUM frames, writes TextMemory, gates core reset.
module text_memory_loader
   import text_memory_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uart_rx,
   output logic                  core_rst,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [1:0]  LANE_LAST = 2'(BYTES_PER_WORD - 1);

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .data       (rx_data),
      .byte_valid (rx_valid),
      .frame_err  (rx_ferr)
   );

   loader_state_t         state_q, state_d;
   logic [7:0]            left_q, left_d;
   logic [1:0]            lane_q, lane_d;
   logic [23:0]           word_q, word_d;
   logic [7:0]            csum_q, csum_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  core_rst_q, core_rst_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  sync_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LD_IDLE;
         left_q     <= '0;
         lane_q     <= '0;
         word_q     <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         left_q     <= left_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign sync_seen = rx_valid && (rx_data == SYNC_BYTE);

   always_comb begin
      state_d    = state_q;
      left_d     = left_q;
      lane_d     = lane_q;
      word_d     = word_q;
      csum_d     = csum_q;
      addr_d     = we_q ? addr_q + 1'b1 : addr_q;
      we_d       = 1'b0;
      wdata_d    = wdata_q;
      core_rst_d = core_rst_q;
      done_d     = done_q;
      error_d    = error_q;
      case (state_q)
         LD_IDLE, LD_RUN: begin
            if (sync_seen) begin
               state_d    = LD_LEN;
               error_d    = 1'b0;
               core_rst_d = 1'b1;
               done_d     = 1'b0;
               addr_d     = '0;
               lane_d     = '0;
               csum_d     = '0;
            end
         end
         LD_LEN: begin
            if (rx_ferr) begin
               error_d = 1'b1;
               state_d = LD_IDLE;
            end else if (rx_valid) begin
               left_d = rx_data;
               if (32'(rx_data) > DEPTH) begin
                  error_d = 1'b1;
                  state_d = LD_IDLE;
               end else if (rx_data == 8'd0) begin
                  state_d = LD_CSUM;
               end else begin
                  state_d = LD_DATA;
               end
            end
         end
         LD_DATA: begin
            if (rx_ferr) begin
               error_d = 1'b1;
               state_d = LD_IDLE;
            end else if (rx_valid) begin
               csum_d = csum_q + rx_data;
               lane_d = lane_q + 1'b1;
               // Earlier bytes sit in word_q low-first, so the 4th byte is the MSB lane.
               if (lane_q == LANE_LAST) begin
                  we_d    = 1'b1;
                  wdata_d = {rx_data, word_q};
                  left_d  = left_q - 1'b1;
                  if (left_q == 8'd1) state_d = LD_CSUM;
               end else begin
                  word_d = {rx_data, word_q[23:8]};
               end
            end
         end
         LD_CSUM: begin
            if (rx_ferr) begin
               error_d = 1'b1;
               state_d = LD_IDLE;
            end else if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d    = LD_RUN;
                  core_rst_d = 1'b0;
                  done_d     = 1'b1;
                  error_d    = 1'b0;
               end else begin
                  error_d = 1'b1;
                  state_d = LD_IDLE;
               end
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   assign core_rst  = core_rst_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
